// File: rtl/mux_nne1_regjistruar.sv
// Registered N-to-1 bus multiplexer with valid/ready on every channel and on the output.
// Channel choice is either direct (S) or round-robin over valid channels starting at ptr.
module mux_nne1_regjistruar #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   localparam int SW   = $clog2(N)
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [N*WIDTH-1:0]   Hyrja,
   input  logic [N-1:0]         HyrjaValid,
   output logic [N-1:0]         HyrjaReady,
   input  logic [SW-1:0]        S,
   input  logic                 Modi,
   output logic [WIDTH-1:0]     Dalja,
   output logic                 DaljaValid,
   input  logic                 DaljaReady,
   output logic [SW-1:0]        Kanali
);

   logic [WIDTH-1:0] dalja_q, dalja_d;
   logic             valid_q, valid_d;
   logic [SW-1:0]    kanali_q, kanali_d;
   logic [SW-1:0]    ptr_q, ptr_d;

   logic             free_s;
   logic             grant_vld_s;
   logic [SW-1:0]    grant_s;
   logic             xfer_s;

   // Reset blocks all consumption so nothing is lost while the output is being cleared.
   assign free_s = !Reset && (!valid_q || DaljaReady);
   assign xfer_s = free_s && grant_vld_s;

   // Grant selection: direct index or first valid channel at/after ptr, wrapping at N.
   always_comb begin
      int idx;
      grant_vld_s = 1'b0;
      grant_s     = {SW{1'b0}};
      idx         = 0;
      if (!Modi) begin
         if (int'(S) < N) begin
            if (HyrjaValid[S]) begin
               grant_vld_s = 1'b1;
               grant_s     = S;
            end else begin
               grant_vld_s = 1'b0;
            end
         end else begin
            grant_vld_s = 1'b0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
               idx = idx - N;
            end else begin
               idx = idx;
            end
            if (!grant_vld_s && HyrjaValid[idx]) begin
               grant_vld_s = 1'b1;
               grant_s     = SW'(idx);
            end else begin
               grant_vld_s = grant_vld_s;
            end
         end
      end
   end

   // One-hot ready toward the granted channel only when the output register can take a word.
   always_comb begin
      HyrjaReady = {N{1'b0}};
      for (int k = 0; k < N; k++) begin
         HyrjaReady[k] = xfer_s && (grant_s == SW'(k));
      end
   end

   // Next-state of the output register and round-robin pointer.
   always_comb begin
      dalja_d  = dalja_q;
      valid_d  = valid_q;
      kanali_d = kanali_q;
      ptr_d    = ptr_q;
      if (xfer_s) begin
         dalja_d  = Hyrja[int'(grant_s)*WIDTH +: WIDTH];
         kanali_d = grant_s;
         valid_d  = 1'b1;
         if (Modi) begin
            ptr_d = (grant_s == SW'(N-1)) ? {SW{1'b0}} : grant_s + SW'(1);
         end else begin
            ptr_d = ptr_q;
         end
      end else if (free_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         dalja_q  <= {WIDTH{1'b0}};
         valid_q  <= 1'b0;
         kanali_q <= {SW{1'b0}};
         ptr_q    <= {SW{1'b0}};
      end else begin
         dalja_q  <= dalja_d;
         valid_q  <= valid_d;
         kanali_q <= kanali_d;
         ptr_q    <= ptr_d;
      end
   end

   assign Dalja      = dalja_q;
   assign DaljaValid = valid_q;
   assign Kanali     = kanali_q;

endmodule

// File: tb/tb_mux_nne1_regjistruar.sv
// Directed testbench for mux_nne1_regjistruar (WIDTH=16, N=4), one task per scenario.
module tb_mux_nne1_regjistruar;

   logic        Clock;
   logic        Reset;
   logic [63:0] Hyrja;
   logic [3:0]  HyrjaValid;
   logic [3:0]  HyrjaReady;
   logic [1:0]  S;
   logic        Modi;
   logic [15:0] Dalja;
   logic        DaljaValid;
   logic        DaljaReady;
   logic [1:0]  Kanali;

   logic [15:0] ch [4];
   int errors;
   int checks;

   assign Hyrja = {ch[3], ch[2], ch[1], ch[0]};

   mux_nne1_regjistruar #(.WIDTH(16), .N(4)) dut (
      .Clock(Clock), .Reset(Reset), .Hyrja(Hyrja), .HyrjaValid(HyrjaValid),
      .HyrjaReady(HyrjaReady), .S(S), .Modi(Modi), .Dalja(Dalja),
      .DaljaValid(DaljaValid), .DaljaReady(DaljaReady), .Kanali(Kanali)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Modi = 1'b1; S = 2'd0; DaljaReady = 1'b1; HyrjaValid = 4'b1111;
      ch[0] = 16'h0000; ch[1] = 16'h0001; ch[2] = 16'h0002; ch[3] = 16'h0003;
      #1;
      checks++; if (HyrjaReady !== 4'b0000) begin errors++; $display("FAIL reset_ready_pre got=%b exp=0000", HyrjaReady); end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++; if (DaljaValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", DaljaValid); end
         checks++; if (Dalja !== 16'h0000) begin errors++; $display("FAIL reset_dalja got=%h exp=0000", Dalja); end
         checks++; if (Kanali !== 2'd0) begin errors++; $display("FAIL reset_kanali got=%0d exp=0", Kanali); end
         checks++; if (HyrjaReady !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", HyrjaReady); end
      end
      Reset = 1'b0;
      #1;
      checks++; if (HyrjaReady !== 4'b0001) begin errors++; $display("FAIL post_reset_rr_ready got=%b exp=0001", HyrjaReady); end
      HyrjaValid = 4'b0000;
      tick();
   endtask

   task automatic test_direct();
      Modi = 1'b0; S = 2'd2; DaljaReady = 1'b1;
      ch[0] = 16'hAAAA; ch[1] = 16'h1234; ch[2] = 16'hBEEF; ch[3] = 16'hCAFE;
      HyrjaValid = 4'b0100;
      #1;
      checks++; if (HyrjaReady !== 4'b0100) begin errors++; $display("FAIL direct_ready got=%b exp=0100", HyrjaReady); end
      tick();
      checks++; if (Dalja !== 16'hBEEF) begin errors++; $display("FAIL direct_dalja got=%h exp=beef", Dalja); end
      checks++; if (Kanali !== 2'd2) begin errors++; $display("FAIL direct_kanali got=%0d exp=2", Kanali); end
      checks++; if (DaljaValid !== 1'b1) begin errors++; $display("FAIL direct_valid got=%b exp=1", DaljaValid); end
      S = 2'd3;
      #1;
      checks++; if (HyrjaReady !== 4'b0000) begin errors++; $display("FAIL direct_invalid_sel got=%b exp=0000", HyrjaReady); end
      tick();
      checks++; if (DaljaValid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", DaljaValid); end
      checks++; if (Dalja !== 16'hBEEF) begin errors++; $display("FAIL drain_hold got=%h exp=beef", Dalja); end
      HyrjaValid = 4'b0000;
   endtask

   task automatic test_backpressure();
      Modi = 1'b0; S = 2'd1; DaljaReady = 1'b0; ch[1] = 16'h1234; HyrjaValid = 4'b0010;
      #1;
      checks++; if (HyrjaReady !== 4'b0010) begin errors++; $display("FAIL bp_first_ready got=%b exp=0010", HyrjaReady); end
      tick();
      checks++; if (Dalja !== 16'h1234 || DaljaValid !== 1'b1) begin errors++; $display("FAIL bp_capture got=%h/%b exp=1234/1", Dalja, DaljaValid); end
      ch[1] = 16'h5678;
      for (int c = 0; c < 5; c++) begin
         checks++; if (HyrjaReady !== 4'b0000) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, HyrjaReady); end
         tick();
         checks++; if (Dalja !== 16'h1234 || DaljaValid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=1234/1", c, Dalja, DaljaValid); end
      end
      DaljaReady = 1'b1;
      #1;
      checks++; if (HyrjaReady !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b exp=0010", HyrjaReady); end
      tick();
      checks++; if (Dalja !== 16'h5678) begin errors++; $display("FAIL bp_resume1 got=%h exp=5678", Dalja); end
      ch[1] = 16'h9ABC;
      tick();
      checks++; if (Dalja !== 16'h9ABC || DaljaValid !== 1'b1) begin errors++; $display("FAIL bp_resume2 got=%h/%b exp=9abc/1", Dalja, DaljaValid); end
      HyrjaValid = 4'b0000;
      tick();
      checks++; if (DaljaValid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", DaljaValid); end
   endtask

   task automatic test_rr_fair();
      Modi = 1'b1; DaljaReady = 1'b1;
      ch[0] = 16'h0000; ch[1] = 16'h0001; ch[2] = 16'h0002; ch[3] = 16'h0003;
      HyrjaValid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (Kanali !== 2'(i % 4) || Dalja !== 16'(i % 4) || DaljaValid !== 1'b1) begin
            errors++; $display("FAIL rr_fair i=%0d got=%0d/%h/%b exp=%0d", i, Kanali, Dalja, DaljaValid, i % 4);
         end
      end
      HyrjaValid = 4'b0000;
      tick();
   endtask

   task automatic test_rr_skip();
      int exp_k [4];
      exp_k = '{3, 1, 3, 1};
      Modi = 1'b1; DaljaReady = 1'b1; HyrjaValid = 4'b0010;
      tick();
      checks++; if (Kanali !== 2'd1) begin errors++; $display("FAIL rr_setup got=%0d exp=1", Kanali); end
      HyrjaValid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (Kanali !== 2'(exp_k[i])) begin errors++; $display("FAIL rr_skip i=%0d got=%0d exp=%0d", i, Kanali, exp_k[i]); end
      end
      Modi = 1'b0; S = 2'd1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (Kanali !== 2'd1 || Dalja !== 16'h0001) begin errors++; $display("FAIL direct_after_rr i=%0d got=%0d/%h exp=1/0001", i, Kanali, Dalja); end
      end
      Modi = 1'b1;
      #1;
      checks++; if (HyrjaReady !== 4'b1000) begin errors++; $display("FAIL ptr_unchanged got=%b exp=1000", HyrjaReady); end
   endtask

   task automatic test_reset_mid();
      Modi = 1'b0; S = 2'd0; ch[0] = 16'hAAAA; HyrjaValid = 4'b0001; DaljaReady = 1'b1;
      tick();
      checks++; if (DaljaValid !== 1'b1 || Dalja !== 16'hAAAA) begin errors++; $display("FAIL mid_setup got=%h/%b exp=aaaa/1", Dalja, DaljaValid); end
      DaljaReady = 1'b0; Reset = 1'b1; Modi = 1'b1; HyrjaValid = 4'b1111;
      #1;
      checks++; if (HyrjaReady !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0000", HyrjaReady); end
      tick();
      checks++; if (DaljaValid !== 1'b0 || Kanali !== 2'd0 || Dalja !== 16'h0000) begin
         errors++; $display("FAIL mid_reset_state got=%h/%b/%0d exp=0000/0/0", Dalja, DaljaValid, Kanali);
      end
      Reset = 1'b0; DaljaReady = 1'b1;
      #1;
      checks++; if (HyrjaReady !== 4'b0001) begin errors++; $display("FAIL mid_reset_ptr got=%b exp=0001", HyrjaReady); end
      HyrjaValid = 4'b0000;
      tick();
   endtask

   initial begin
      errors = 0; checks = 0;
      Reset = 1'b1; Modi = 1'b0; S = 2'd0; DaljaReady = 1'b0; HyrjaValid = 4'b0000;
      for (int k = 0; k < 4; k++) ch[k] = 16'h0000;
      test_reset();
      test_direct();
      test_backpressure();
      test_rr_fair();
      test_rr_skip();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
